pmod_cls_spi_responder: RTL and testbench

- SPI target (responder) model of the Digilent PMOD CLS display. It is the far end of the CLS SPI bus driven by our custom CLS driver.
- Deserialises mode-0 SPI bytes and parses the CLS escape-sequence command set.
- Maintains a 2x16 character buffer and exposes it to testbenches and on-board loopback checks.
- Synthesisable; runs on the 20 MHz system clock and oversamples the SPI bus.

---
 rtl/pmod_cls_spi_responder.sv | 226 ++++++++++++++++++++++
 tb/tb_pmod_cls_spi_responder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmod_cls_spi_responder.sv
// SPI mode-0 responder modelling the Digilent PMOD CLS display: deserialises bytes,
// parses the CLS escape command set and keeps a 2x16 character buffer.
module pmod_cls_spi_responder #(
  parameter int parm_sync_stages = 2,
  parameter int parm_num_bits    = 8
) (
  input  logic           i_clk_20mhz,
  input  logic           i_rst_20mhz,
  input  logic           ei_sck,
  input  logic           ei_csn,
  input  logic           ei_copi,
  output logic           eo_cipo_o,
  output logic           eo_cipo_t,
  output logic [7:0]     o_rx_byte,
  output logic           o_rx_valid,
  output logic           o_frame_err,
  output logic           o_cmd_clear,
  output logic           o_cmd_cursor,
  output logic           o_cmd_err,
  output logic           o_row,
  output logic [3:0]     o_col,
  output logic [127:0]   o_line1,
  output logic [127:0]   o_line2,
  output logic [1:0]     o_dbg_state
);

  localparam int NB = parm_num_bits;
  localparam int AW = parm_num_bits + 4;
  localparam logic [127:0] BLANK = {16{8'h20}};

  typedef enum logic [1:0] {ST_TEXT, ST_ESC, ST_P0, ST_P1} t_state;

  logic [parm_sync_stages-1:0] sck_sync_q, sck_sync_d;
  logic [parm_sync_stages-1:0] csn_sync_q, csn_sync_d;
  logic [parm_sync_stages-1:0] copi_sync_q, copi_sync_d;
  logic          sck_prev_q, sck_prev_d, csn_prev_q, csn_prev_d;
  logic          sck_s, csn_s, copi_s, sck_rise, csn_rise;
  logic [7:0]    sh_q, sh_d, rx_byte_q, rx_byte_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          rx_valid_q, rx_valid_d, frame_err_q, frame_err_d;
  t_state        state_q, state_d;
  logic [NB-1:0] p0_q, p0_d, p1_q, p1_d, cur_col;
  logic          row_q, row_d, do_cursor;
  logic [3:0]    col_q, col_d;
  logic [127:0]  line1_q, line1_d, line2_q, line2_d;
  logic          clear_q, clear_d, cursor_q, cursor_d, err_q, err_d;
  logic [6:0]    wr_idx;

  // Decimal accumulate, pinned at the all-ones value once it overflows.
  function automatic logic [NB-1:0] sat_acc(input logic [NB-1:0] p, input logic [3:0] d);
    logic [AW-1:0] w;
    w = AW'(p) * AW'(10) + AW'(d);
    if (w[AW-1:NB] != '0) return '1;
    return w[NB-1:0];
  endfunction

  always_comb begin
    sck_sync_d  = {sck_sync_q[parm_sync_stages-2:0], ei_sck};
    csn_sync_d  = {csn_sync_q[parm_sync_stages-2:0], ei_csn};
    copi_sync_d = {copi_sync_q[parm_sync_stages-2:0], ei_copi};
    sck_s       = sck_sync_q[parm_sync_stages-1];
    csn_s       = csn_sync_q[parm_sync_stages-1];
    copi_s      = copi_sync_q[parm_sync_stages-1];
    sck_rise    = !sck_prev_q && sck_s && !csn_s;
    csn_rise    = !csn_prev_q && csn_s;
    sck_prev_d  = sck_s;
    csn_prev_d  = csn_s;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    rx_byte_d   = rx_byte_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    if (sck_rise) begin
      sh_d  = {sh_q[6:0], copi_s};
      cnt_d = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        rx_byte_d  = sh_d;
        rx_valid_d = 1'b1;
      end
    end else if (csn_rise && cnt_q != 3'd0) begin
      frame_err_d = 1'b1;
      cnt_d       = 3'd0;
    end
  end

  always_comb begin
    state_d   = state_q;
    p0_d      = p0_q;
    p1_d      = p1_q;
    row_d     = row_q;
    col_d     = col_q;
    line1_d   = line1_q;
    line2_d   = line2_q;
    clear_d   = 1'b0;
    cursor_d  = 1'b0;
    err_d     = 1'b0;
    do_cursor = 1'b0;
    cur_col   = '0;
    wr_idx    = {~col_q, 3'b000};
    if (rx_valid_q) begin
      case (state_q)
        ST_TEXT: begin
          if (rx_byte_q == 8'h1B) begin
            state_d = ST_ESC;
          end else if (rx_byte_q >= 8'h20 && rx_byte_q <= 8'h7E) begin
            if (row_q) line2_d[wr_idx +: 8] = rx_byte_q;
            else       line1_d[wr_idx +: 8] = rx_byte_q;
            col_d = col_q + 4'd1;
          end
        end
        ST_ESC: begin
          if (rx_byte_q == 8'h5B) begin
            p0_d    = '0;
            p1_d    = '0;
            state_d = ST_P0;
          end else begin
            err_d   = 1'b1;
            state_d = ST_TEXT;
          end
        end
        ST_P0: begin
          if (rx_byte_q >= 8'h30 && rx_byte_q <= 8'h39) begin
            p0_d = sat_acc(p0_q, rx_byte_q[3:0]);
          end else if (rx_byte_q == 8'h3B) begin
            state_d = ST_P1;
          end else if (rx_byte_q == 8'h6A) begin
            line1_d = BLANK;
            line2_d = BLANK;
            row_d   = 1'b0;
            col_d   = 4'd0;
            clear_d = 1'b1;
            state_d = ST_TEXT;
          end else if (rx_byte_q == 8'h48) begin
            do_cursor = 1'b1;
          end else begin
            err_d   = 1'b1;
            state_d = ST_TEXT;
          end
        end
        default: begin
          if (rx_byte_q >= 8'h30 && rx_byte_q <= 8'h39) begin
            p1_d = sat_acc(p1_q, rx_byte_q[3:0]);
          end else if (rx_byte_q == 8'h48) begin
            do_cursor = 1'b1;
            cur_col   = p1_q;
          end else begin
            err_d   = 1'b1;
            state_d = ST_TEXT;
          end
        end
      endcase
      // Out-of-range targets leave the cursor where it was.
      if (do_cursor) begin
        state_d = ST_TEXT;
        if (p0_q <= NB'(1) && cur_col <= NB'(15)) begin
          row_d    = p0_q[0];
          col_d    = cur_col[3:0];
          cursor_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
    if (i_rst_20mhz) begin
      sck_sync_q  <= '0;
      csn_sync_q  <= '1;
      copi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      csn_prev_q  <= 1'b1;
      sh_q        <= 8'h00;
      cnt_q       <= 3'd0;
      rx_byte_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      state_q     <= ST_TEXT;
      p0_q        <= '0;
      p1_q        <= '0;
      row_q       <= 1'b0;
      col_q       <= 4'd0;
      line1_q     <= BLANK;
      line2_q     <= BLANK;
      clear_q     <= 1'b0;
      cursor_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      csn_sync_q  <= csn_sync_d;
      copi_sync_q <= copi_sync_d;
      sck_prev_q  <= sck_prev_d;
      csn_prev_q  <= csn_prev_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      state_q     <= state_d;
      p0_q        <= p0_d;
      p1_q        <= p1_d;
      row_q       <= row_d;
      col_q       <= col_d;
      line1_q     <= line1_d;
      line2_q     <= line2_d;
      clear_q     <= clear_d;
      cursor_q    <= cursor_d;
      err_q       <= err_d;
    end
  end

  assign eo_cipo_o    = 1'b0;
  assign eo_cipo_t    = 1'b1;
  assign o_rx_byte    = rx_byte_q;
  assign o_rx_valid   = rx_valid_q;
  assign o_frame_err  = frame_err_q;
  assign o_cmd_clear  = clear_q;
  assign o_cmd_cursor = cursor_q;
  assign o_cmd_err    = err_q;
  assign o_row        = row_q;
  assign o_col        = col_q;
  assign o_line1      = line1_q;
  assign o_line2      = line2_q;
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_pmod_cls_spi_responder.sv
// Bench for pmod_cls_spi_responder: directed CLS command sequences plus random
// tokens, checked against a display model that re-parses escape strings as text.
`timescale 1ns/1ps
module tb_pmod_cls_spi_responder;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sck = 1'b0;
  logic         csn = 1'b1;
  logic         copi = 1'b0;
  logic         cipo_o, cipo_t, rx_valid, frame_err, cmd_clear, cmd_cursor, cmd_err, row;
  logic [7:0]   rx_byte;
  logic [3:0]   col;
  logic [127:0] line1, line2;
  logic [1:0]   dbg_state;

  int checks = 0;
  int failures = 0;

  // clock / reset
  always #25 clk = ~clk;

  pmod_cls_spi_responder dut (
    .i_clk_20mhz(clk), .i_rst_20mhz(rst), .ei_sck(sck), .ei_csn(csn), .ei_copi(copi),
    .eo_cipo_o(cipo_o), .eo_cipo_t(cipo_t), .o_rx_byte(rx_byte), .o_rx_valid(rx_valid),
    .o_frame_err(frame_err), .o_cmd_clear(cmd_clear), .o_cmd_cursor(cmd_cursor),
    .o_cmd_err(cmd_err), .o_row(row), .o_col(col), .o_line1(line1), .o_line2(line2),
    .o_dbg_state(dbg_state)
  );

  // pulse monitor
  int n_rxv = 0, n_ferr = 0, n_clear = 0, n_cursor = 0, n_err = 0;
  logic [7:0] got_q[$];
  always @(negedge clk) begin
    if (rx_valid) begin
      n_rxv++;
      got_q.push_back(rx_byte);
    end
    if (frame_err)  n_ferr++;
    if (cmd_clear)  n_clear++;
    if (cmd_cursor) n_cursor++;
    if (cmd_err)    n_err++;
  end

  // display model
  logic [7:0] mline [2][16];
  int         mrow, mcol;
  bit         in_esc;
  logic [7:0] esc[$];
  logic [7:0] exp_q[$];
  logic [7:0] tx_q[$];
  int e_rxv = 0, e_ferr = 0, e_clear = 0, e_cursor = 0, e_err = 0;

  task automatic model_reset();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 16; c++) mline[r][c] = 8'h20;
    mrow = 0; mcol = 0; in_esc = 0; esc.delete();
  endtask

  function automatic logic [127:0] pack(int r);
    logic [127:0] v;
    for (int c = 0; c < 16; c++) v[127-8*c -: 8] = mline[r][c];
    return v;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    int semi, k;
    int p[2];
    e_rxv++;
    exp_q.push_back(b);
    if (!in_esc) begin
      if (b == 8'h1B) begin
        in_esc = 1; esc.delete();
      end else if (b >= 8'h20 && b <= 8'h7E) begin
        mline[mrow][mcol] = b;
        mcol = (mcol + 1) % 16;
      end
      return;
    end
    esc.push_back(b);
    if (esc.size() == 1) begin
      if (b != 8'h5B) begin e_err++; in_esc = 0; end
      return;
    end
    semi = 0;
    for (int i = 1; i < esc.size() - 1; i++) if (esc[i] == 8'h3B) semi++;
    if (b >= 8'h30 && b <= 8'h39) return;
    if (b == 8'h3B && semi == 0) return;
    in_esc = 0;
    if (b == 8'h6A && semi == 0) begin
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 16; c++) mline[r][c] = 8'h20;
      mrow = 0; mcol = 0; e_clear++;
    end else if (b == 8'h48) begin
      p[0] = 0; p[1] = 0; k = 0;
      for (int i = 1; i < esc.size() - 1; i++) begin
        if (esc[i] == 8'h3B) k = 1;
        else begin
          p[k] = p[k] * 10 + int'(esc[i]) - 48;
          if (p[k] > 255) p[k] = 255;
        end
      end
      if (p[0] <= 1 && p[1] <= 15) begin mrow = p[0]; mcol = p[1]; e_cursor++; end
      else e_err++;
    end else begin
      e_err++;
    end
  endtask

  // driver tasks
  task automatic spi_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      copi = b[7-i];
      repeat (16) @(negedge clk);
      sck = 1'b1;
      repeat (16) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic send_tx();
    csn = 1'b0;
    repeat (8) @(negedge clk);
    while (tx_q.size() > 0) begin
      logic [7:0] b;
      b = tx_q.pop_front();
      model_byte(b);
      spi_bits(b, 8);
    end
    repeat (8) @(negedge clk);
    csn = 1'b1;
    repeat (24) @(negedge clk);
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) tx_q.push_back(s[i]);
  endtask

  task automatic push_num(input int v);
    push_str($sformatf("%0d", v));
  endtask

  // scoreboard
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".line1"}, line1, pack(0));
    chk({tag, ".line2"}, line2, pack(1));
    chk({tag, ".row"}, 128'(row), 128'(mrow));
    chk({tag, ".col"}, 128'(col), 128'(mcol));
    chk({tag, ".n_rxv"}, 128'(n_rxv), 128'(e_rxv));
    chk({tag, ".n_ferr"}, 128'(n_ferr), 128'(e_ferr));
    chk({tag, ".n_clear"}, 128'(n_clear), 128'(e_clear));
    chk({tag, ".n_cursor"}, 128'(n_cursor), 128'(e_cursor));
    chk({tag, ".n_err"}, 128'(n_err), 128'(e_err));
    chk({tag, ".cipo"}, {126'd0, cipo_t, cipo_o}, 128'd2);
    chk({tag, ".rx_count"}, 128'(got_q.size()), 128'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0)
      chk({tag, ".rx_byte"}, 128'(got_q.pop_front()), 128'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".line1"}, line1, {16{8'h20}});
    chk({tag, ".line2"}, line2, {16{8'h20}});
    chk({tag, ".rowcol"}, {123'd0, row, col}, 128'd0);
    chk({tag, ".rx_byte"}, 128'(rx_byte), 128'd0);
    chk({tag, ".pulses"}, {123'd0, rx_valid, frame_err, cmd_clear, cmd_cursor, cmd_err}, 128'd0);
    chk({tag, ".cipo"}, {126'd0, cipo_t, cipo_o}, 128'd2);
  endtask

  initial begin
    model_reset();
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // reset, then idle
    check_reset_values("reset");
    check_all("idle");

    // clear then HELLO
    tx_q.push_back(8'h1B); push_str("[jHELLO");
    send_tx();
    check_all("hello");

    // cursor to row 1 col 3, then AB
    tx_q.push_back(8'h1B); push_str("[1;3HAB");
    send_tx();
    check_all("cursor_ab");

    // out-of-range cursor targets
    tx_q.push_back(8'h1B); push_str("[2;0H");
    send_tx();
    check_all("bad_row");
    tx_q.push_back(8'h1B); push_str("[0;16H");
    send_tx();
    check_all("bad_col");

    // partial byte then a full 'Z'
    csn = 1'b0;
    repeat (8) @(negedge clk);
    spi_bits(8'($urandom_range(0, 255)), 5);
    repeat (8) @(negedge clk);
    csn = 1'b1;
    e_ferr++;
    repeat (24) @(negedge clk);
    push_str("Z");
    send_tx();
    check_all("frame_err");

    // random tokens
    for (int t = 0; t < 22; t++) begin
      int kind;
      kind = $urandom_range(0, 5);
      case (kind)
        0: for (int i = 0; i < $urandom_range(1, 3); i++) tx_q.push_back(8'($urandom_range(32, 126)));
        1: begin
          tx_q.push_back(8'h1B); push_str("[");
          push_num($urandom_range(0, 2));
          if ($urandom_range(0, 3) != 0) begin push_str(";"); push_num($urandom_range(0, 17)); end
          push_str("H");
        end
        2: begin tx_q.push_back(8'h1B); push_str("[j"); end
        3: begin tx_q.push_back(8'h1B); tx_q.push_back(8'($urandom_range(0, 255))); end
        4: tx_q.push_back(8'($urandom_range(0, 255)));
        default: begin
          tx_q.push_back(8'h1B); push_str("[");
          push_num($urandom_range(0, 999)); push_str(";");
          push_str($sformatf("%03d", $urandom_range(0, 20))); push_str("H");
        end
      endcase
      send_tx();
      check_all($sformatf("rand%0d", t));
    end

    // 17 characters on row 0 wrap back to column 0
    tx_q.push_back(8'h1B); push_str("[0;0H");
    for (int i = 0; i < 17; i++) tx_q.push_back(8'($urandom_range(33, 126)));
    send_tx();
    check_all("wrap17");

    // open escape, then reset in the middle of a byte
    tx_q.push_back(8'h1B); push_str("[1");
    send_tx();
    check_all("open_esc");
    csn = 1'b0;
    repeat (8) @(negedge clk);
    spi_bits(8'hA5, 3);
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_values("mid_reset");
    rst = 1'b0;
    repeat (8) @(negedge clk);
    csn = 1'b1;
    repeat (24) @(negedge clk);
    check_all("after_reset");
    push_str("Q");
    send_tx();
    check_all("post_reset_text");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
